mult_div_unit: RTL and testbench

- E-stage multiply/divide unit of the 5-stage MIPS pipeline; owns the architectural HI/LO registers.
- Produces the `busy` handshake that the hazard/stall logic consumes. That logic stalls any multdiv instruction in D while `busy | start` is asserted in E.
- Executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, MTHI/MTLO as single-cycle writes, and supplies HI/LO read data for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 114 +++++++++++
 tb/tb_mult_div_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// ==== mult_div_unit : MIPS E-stage multiply/divide unit owning HI/LO ====
// ==== Revision 1.0                                                     ====
`default_nettype none

module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_we;

  // op[1] selects divide, op[0] selects unsigned
  logic          is_div;
  logic          is_signed;
  assign is_div    = op[1];
  assign is_signed = ~op[0];

  // One 64-bit multiplier serves both flavours: sign-extending the operands
  // makes the low 64 bits of the unsigned product equal the signed product.
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  assign ext_a = {{32{A[31] & is_signed}}, A};
  assign ext_b = {{32{B[31] & is_signed}}, B};
  assign prod  = ext_a * ext_b;

  // Divide on magnitudes, then restore signs (quotient toward zero,
  // remainder follows the dividend). 0x80000000/-1 falls out naturally.
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_by_zero;

  assign a_neg       = is_signed & A[31];
  assign b_neg       = is_signed & B[31];
  assign mag_a       = a_neg ? (~A + 32'd1) : A;
  assign mag_b       = b_neg ? (~B + 32'd1) : B;
  assign div_by_zero = (B == 32'd0);
  assign safe_b      = div_by_zero ? 32'd1 : mag_b;
  assign q_mag       = mag_a / safe_b;
  assign r_mag       = mag_a % safe_b;
  assign quot        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem         = a_neg ? (~r_mag + 32'd1) : r_mag;

  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic [CW-1:0] load_cnt;
  assign res_hi   = is_div ? rem  : prod[63:32];
  assign res_lo   = is_div ? quot : prod[31:0];
  assign load_cnt = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      HI      <= 32'd0;
      LO      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
    end else if (!busy) begin
      if (wr_hi) HI <= A;
      if (wr_lo) LO <= A;
      if (start) begin
        busy    <= 1'b1;
        cnt     <= load_cnt;
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_we <= ~(is_div & div_by_zero);
      end
    end else if (cnt == CW'(1)) begin
      // Final edge of the window: drop busy and commit in the same edge.
      busy <= 1'b0;
      cnt  <= '0;
      if (pend_we) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign out = rd_sel ? HI : LO;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ==== tb_mult_div_unit : directed self-checking bench for mult_div_unit ====
// ==== Revision 1.0                                                       ====
`default_nettype none

module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        wr_hi;
  logic        wr_lo;
  logic        rd_sel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .rd_sel(rd_sel),
    .busy(busy), .HI(HI), .LO(LO), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count cycles until busy drops (bounded); expired bound shows as a count mismatch.
  task automatic wait_idle(input string tag, input int exp_cycles);
    int cycles;
    cycles = 0;
    while (busy && cycles < 50) begin
      tick();
      cycles++;
    end
    check(tag, cycles, exp_cycles);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] old_hi,
                        input logic [31:0] old_lo, input int exp_cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1; op = o; A = a; B = b;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_hold_hi"}, HI, old_hi);
    check({tag, "_hold_lo"}, LO, old_lo);
    wait_idle({tag, "_cycles"}, exp_cycles);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; rd_sel = 1'b0;
    repeat (2) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b0;
    tick();

    run_op("mult",  2'b00, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 2'b01, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5,
           32'h00000002, 32'hFFFFFFFA);
    run_op("div",   2'b10, 32'hFFFFFFF9, 32'd2, 32'h00000002, 32'hFFFFFFFA, 10,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",  2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10,
           32'h00000001, 32'h7FFFFFFC);

    // MTHI / MTLO then divide by zero
    wr_hi = 1'b1; A = 32'h12345678;
    tick();
    wr_hi = 1'b0;
    check("mthi", HI, 32'h12345678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    wr_lo = 1'b1; A = 32'h9ABCDEF0;
    tick();
    wr_lo = 1'b0;
    check("mtlo", LO, 32'h9ABCDEF0);
    run_op("div0", 2'b10, 32'd55, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10,
           32'h12345678, 32'h9ABCDEF0);
    rd_sel = 1'b1; #1;
    check("out_hi", out, 32'h12345678);
    rd_sel = 1'b0; #1;
    check("out_lo", out, 32'h9ABCDEF0);

    // Start + MTLO during busy window are ignored
    start = 1'b1; op = 2'b00; A = 32'd5; B = 32'd7;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1; op = 2'b11; A = 32'd100; B = 32'd3; wr_lo = 1'b1;
    tick();
    start = 1'b0; wr_lo = 1'b0;
    check("viol_lo_hold", LO, 32'h9ABCDEF0);
    wait_idle("viol_cycles", 2);
    check("viol_hi", HI, 32'd0);
    check("viol_lo", LO, 32'd35);
    tick();
    check("viol_no_restart", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a divide
    start = 1'b1; op = 2'b10; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    #1 reset = 1'b0;
    repeat (12) tick();
    check("arst_nocommit_hi", HI, 32'd0);
    check("arst_nocommit_lo", LO, 32'd0);
    check("arst_idle", {31'd0, busy}, 32'd0);

    // Signed overflow divide, then back-to-back MULT on the falling edge
    start = 1'b1; op = 2'b10; A = 32'h80000000; B = 32'hFFFFFFFF;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("ovf_busy9", {31'd0, busy}, 32'd1);
    start = 1'b1; op = 2'b00; A = 32'd3; B = 32'd4;
    tick();
    check("b2b_not_accepted", {31'd0, busy}, 32'd0);
    check("ovf_lo", LO, 32'h80000000);
    check("ovf_hi", HI, 32'h00000000);
    tick();
    start = 1'b0;
    check("b2b_accepted", {31'd0, busy}, 32'd1);
    wait_idle("b2b_cycles", 5);
    check("b2b_lo", LO, 32'd12);
    check("b2b_hi", HI, 32'd0);

    // MTHI together with an accepted start: write now, commit later overwrites
    start = 1'b1; wr_hi = 1'b1; op = 2'b01; A = 32'd2; B = 32'd3;
    tick();
    start = 1'b0; wr_hi = 1'b0;
    check("same_mthi", HI, 32'd2);
    check("same_busy", {31'd0, busy}, 32'd1);
    wait_idle("same_cycles", 5);
    check("same_hi", HI, 32'd0);
    check("same_lo", LO, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
